fft_reorder_buffer: RTL
=======================

FFT_REORDER_BUFFER -- requirements
Module: fft_reorder_buffer

Interface
REQ-001 SHALL have parameter DW, default 17: width of each real/imaginary sample component.
REQ-002 SHALL have parameter LOG2N, default 6: log2 of frame length N (legal 2..10).
REQ-003 SHALL have parameter BITREV, default 1: 1 = bit-reversed readout order, 0 = natural order.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port push_in  input  1  input sample valid.
REQ-007 SHALL have port First_Data  input  1  qualifies push_in sample as index 0 of a frame.
REQ-008 SHALL have port DinR  input  DW  real part of input sample.
REQ-009 SHALL have port DinI  input  DW  imaginary part of input sample.
REQ-010 SHALL have port out_stall  input  1  downstream hold request.
REQ-011 SHALL have port push_out  output  1  output sample valid.
REQ-012 SHALL have port first_out  output  1  marks output sample 0 of a frame.
REQ-013 SHALL have port DoutR  output  DW  real part of output sample.
REQ-014 SHALL have port DoutI  output  DW  imaginary part of output sample.
REQ-015 SHALL have port sync_err  output  1  one-cycle pulse on framing violation.
REQ-016 SHALL have port ovf_err  output  1  one-cycle pulse per sample dropped for lack of a free bank.

Function
REQ-017 SHALL hold two N-entry banks (ping-pong), each flagged EMPTY, FILLING or FULL.
REQ-018 Write FSM SHALL have states W_HUNT (wait for First_Data), W_FILL (index 1..N-1).
REQ-019 W_HUNT: push_in&First_Data with an EMPTY bank at the sampling edge -> write index 0, go W_FILL; lower-numbered EMPTY bank chosen first.
REQ-020 W_HUNT: push_in&First_Data with no EMPTY bank -> sample dropped, ovf_err pulse, stay W_HUNT; a bank freed on the same edge does not count as EMPTY.
REQ-021 W_HUNT: push_in without First_Data -> sample dropped, sync_err pulse.
REQ-022 W_FILL: push_in without First_Data -> write at next index; writing index N-1 marks bank FULL, go W_HUNT.
REQ-023 W_FILL: push_in&First_Data -> sync_err pulse, sample written at index 0 of same bank, index restarts (partial frame discarded).
REQ-024 Gaps (push_in low) SHALL be allowed anywhere within a frame without effect.
REQ-025 Read FSM SHALL have states R_IDLE, R_STREAM; R_IDLE -> R_STREAM when a bank is FULL (oldest first).
REQ-026 R_STREAM SHALL present output k (k=0..N-1) = stored index bitrev_LOG2N(k) if BITREV=1, else k.
REQ-027 Outputs SHALL be registered; first push_out asserts on the second rising edge after the edge capturing index N-1.
REQ-028 first_out SHALL be high exactly with k=0; push_out high for N transfers per frame.
REQ-029 out_stall high at an edge: read counter not advanced, push_out/first_out 0 after that edge, DoutR/DoutI hold; stall in R_IDLE has no effect.
REQ-030 After k=N-1 transfer the bank SHALL become EMPTY on that edge; if the other bank is FULL streaming continues next edge with no bubble.
REQ-031 Writing and reading SHALL proceed concurrently on different banks; a bank is never written while FULL or streaming.
REQ-032 DoutR/DoutI SHALL pass data bit-exact, no scaling or sign change.

Reset
REQ-033 reset high SHALL immediately force push_out, first_out, sync_err, ovf_err, DoutR, DoutI to 0, both banks EMPTY, W_HUNT, R_IDLE.
REQ-034 Reset mid-frame or mid-stream SHALL discard all buffered data; no output until a new complete frame.

Verification (LOG2N=3, N=8, BITREV=1 unless stated)
REQ-035 Frame DinR=0..7 (First_Data on 0), DinI=-DinR, no stall -> DoutR 0,4,2,6,1,5,3,7 on 8 consecutive push_out, first_out with 0, first push_out 2 edges after capture of 7.
REQ-036 Same with BITREV=0 -> DoutR 0..7 natural order.
REQ-037 Three back-to-back frames, no gaps -> frames 1,2 stream contiguously; frame 3 accepted once bank frees, else dropped with 8 ovf_err pulses.
REQ-038 First_Data at input index 5, then 8 good samples -> one sync_err pulse, output frame contains only the restarted 8 samples.
REQ-039 out_stall high 3 cycles during k=3 -> push_out low 3 cycles, DoutR held at 6, resume with 1, no sample lost or repeated.
REQ-040 reset pulse at input index 4 and during output k=2 -> outputs 0 immediately, no push_out until next full frame.

Source files
------------

// File: rtl/fft_reorder_buffer_if.sv
// Sample stream bundle for the FFT reorder buffer: input samples with frame marker, reordered output with error pulses.
// Slave side accepts push_in samples whenever they arrive; the master holds the output with out_stall.
interface fft_reorder_buffer_if #(
   parameter int DW = 17
);
   logic          push_in;
   logic          First_Data;
   logic [DW-1:0] DinR;
   logic [DW-1:0] DinI;
   logic          out_stall;
   logic          push_out;
   logic          first_out;
   logic [DW-1:0] DoutR;
   logic [DW-1:0] DoutI;
   logic          sync_err;
   logic          ovf_err;

   modport master (
      output push_in, First_Data, DinR, DinI, out_stall,
      input  push_out, first_out, DoutR, DoutI, sync_err, ovf_err
   );

   modport slave (
      input  push_in, First_Data, DinR, DinI, out_stall,
      output push_out, first_out, DoutR, DoutI, sync_err, ovf_err
   );
endinterface

// File: rtl/fft_reorder_buffer.sv
// Ping-pong frame buffer reordering FFT output (bit-reversed or natural); first output 2 edges after the last sample.
// Input is never stalled (samples without a free bank are dropped with ovf_err); out_stall freezes the read side.
module fft_reorder_buffer #(
   parameter int DW     = 17,
   parameter int LOG2N  = 6,
   parameter int BITREV = 1
) (
   input logic                clk,
   input logic                reset,
   fft_reorder_buffer_if.slave bus
);
   localparam int N = 1 << LOG2N;
   localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

   typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_t;
   typedef enum logic {W_HUNT, W_FILL} wstate_t;
   typedef enum logic {R_IDLE, R_STREAM} rstate_t;

   logic [DW-1:0] mem_r [2*N];
   logic [DW-1:0] mem_i [2*N];

   bank_t            bank_st [2];
   bank_t            bank_st_nxt [2];
   wstate_t          w_state, w_state_nxt;
   logic             w_bank, w_bank_nxt;
   logic [LOG2N-1:0] w_idx, w_idx_nxt;
   logic             drop, drop_nxt;
   logic             wr_en;
   logic [LOG2N:0]   wr_addr;
   logic             sync_nxt, ovf_nxt;

   rstate_t          r_state, r_state_nxt;
   logic             r_bank, r_bank_nxt;
   logic [LOG2N-1:0] r_cnt, r_cnt_nxt;
   logic             rd_en, free_en, first_nxt;
   logic [LOG2N:0]   rd_addr;

   logic             push_out_q, first_out_q, sync_err_q, ovf_err_q;
   logic [DW-1:0]    dout_r_q, dout_i_q;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      for (int i = 0; i < LOG2N; i++) bitrev[i] = v[LOG2N-1-i];
   endfunction

   always_comb begin
      r_state_nxt = r_state;
      r_bank_nxt  = r_bank;
      r_cnt_nxt   = r_cnt;
      rd_en       = 1'b0;
      free_en     = 1'b0;
      first_nxt   = 1'b0;
      rd_addr     = {r_bank, (BITREV != 0) ? bitrev(r_cnt) : r_cnt};
      case (r_state)
         R_IDLE: begin
            if (bank_st[0] == B_FULL) begin
               r_state_nxt = R_STREAM;
               r_bank_nxt  = 1'b0;
               r_cnt_nxt   = '0;
            end else if (bank_st[1] == B_FULL) begin
               r_state_nxt = R_STREAM;
               r_bank_nxt  = 1'b1;
               r_cnt_nxt   = '0;
            end
         end
         R_STREAM: begin
            if (!bus.out_stall) begin
               rd_en     = 1'b1;
               first_nxt = (r_cnt == '0);
               r_cnt_nxt = r_cnt + LOG2N'(1);
               if (r_cnt == LAST) begin
                  free_en   = 1'b1;
                  r_cnt_nxt = '0;
                  // The other bank can only be FULL here if it completed while this one streamed, so it is the older frame.
                  if (bank_st[~r_bank] == B_FULL) r_bank_nxt = ~r_bank;
                  else                            r_state_nxt = R_IDLE;
               end
            end
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      w_state_nxt = w_state;
      w_bank_nxt  = w_bank;
      w_idx_nxt   = w_idx;
      drop_nxt    = drop;
      wr_en       = 1'b0;
      wr_addr     = {w_bank, w_idx};
      sync_nxt    = 1'b0;
      ovf_nxt     = 1'b0;
      bank_st_nxt = bank_st;
      if (free_en) bank_st_nxt[r_bank] = B_EMPTY;
      if (bus.push_in) begin
         case (w_state)
            W_HUNT: begin
               if (bus.First_Data) begin
                  drop_nxt = 1'b0;
                  if (bank_st[0] == B_EMPTY || bank_st[1] == B_EMPTY) begin
                     w_bank_nxt              = (bank_st[0] == B_EMPTY) ? 1'b0 : 1'b1;
                     wr_en                   = 1'b1;
                     wr_addr                 = {w_bank_nxt, {LOG2N{1'b0}}};
                     bank_st_nxt[w_bank_nxt] = B_FILLING;
                     w_idx_nxt               = LOG2N'(1);
                     w_state_nxt             = W_FILL;
                  end else begin
                     ovf_nxt  = 1'b1;
                     drop_nxt = 1'b1;
                  end
               // Remaining samples of a frame refused for lack of a bank count as overflow, not as framing errors.
               end else if (drop) begin
                  ovf_nxt = 1'b1;
               end else begin
                  sync_nxt = 1'b1;
               end
            end
            W_FILL: begin
               wr_en = 1'b1;
               if (bus.First_Data) begin
                  sync_nxt  = 1'b1;
                  wr_addr   = {w_bank, {LOG2N{1'b0}}};
                  w_idx_nxt = LOG2N'(1);
               end else begin
                  w_idx_nxt = w_idx + LOG2N'(1);
                  if (w_idx == LAST) begin
                     bank_st_nxt[w_bank] = B_FULL;
                     w_state_nxt         = W_HUNT;
                     w_idx_nxt           = '0;
                  end
               end
            end
            default: w_state_nxt = W_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bank_st[0]  <= B_EMPTY;
         bank_st[1]  <= B_EMPTY;
         w_state     <= W_HUNT;
         w_bank      <= 1'b0;
         w_idx       <= '0;
         drop        <= 1'b0;
         r_state     <= R_IDLE;
         r_bank      <= 1'b0;
         r_cnt       <= '0;
         push_out_q  <= 1'b0;
         first_out_q <= 1'b0;
         sync_err_q  <= 1'b0;
         ovf_err_q   <= 1'b0;
         dout_r_q    <= '0;
         dout_i_q    <= '0;
      end else begin
         bank_st[0]  <= bank_st_nxt[0];
         bank_st[1]  <= bank_st_nxt[1];
         w_state     <= w_state_nxt;
         w_bank      <= w_bank_nxt;
         w_idx       <= w_idx_nxt;
         drop        <= drop_nxt;
         r_state     <= r_state_nxt;
         r_bank      <= r_bank_nxt;
         r_cnt       <= r_cnt_nxt;
         push_out_q  <= rd_en;
         first_out_q <= first_nxt;
         sync_err_q  <= sync_nxt;
         ovf_err_q   <= ovf_nxt;
         if (rd_en) begin
            dout_r_q <= mem_r[rd_addr];
            dout_i_q <= mem_i[rd_addr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= bus.DinR;
         mem_i[wr_addr] <= bus.DinI;
      end
   end

   assign bus.push_out  = push_out_q;
   assign bus.first_out = first_out_q;
   assign bus.DoutR     = dout_r_q;
   assign bus.DoutI     = dout_i_q;
   assign bus.sync_err  = sync_err_q;
   assign bus.ovf_err   = ovf_err_q;
endmodule
